tmds_deserializer: RTL

Three-lane TMDS receive front end: samples one serial bit per lane per bit-clock cycle, LSB first, and assembles 10-bit TMDS characters. Each lane independently finds its character boundary by bit-slipping until it sees a run of TMDS control tokens. It then holds lock and delivers one 10-bit character per 10 cycles to the downstream TMDS decoder. It sits directly behind the differential input buffers of the HDMI receive path, mirroring the transmit serializer.

---
 rtl/tmds_pkg.sv | 23 ++
 rtl/tmds_lane_aligner.sv | 129 ++++++++++++
 rtl/tmds_deserializer.sv | 44 ++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: character width, control tokens and
// the per-lane boundary aligner state encoding.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } aligner_state_t;

  function automatic logic is_ctrl_token(input logic [TMDS_WORD_W-1:0] w);
    return (w == CTRL_TOKEN_0) || (w == CTRL_TOKEN_1) ||
           (w == CTRL_TOKEN_2) || (w == CTRL_TOKEN_3);
  endfunction

endpackage

// File: rtl/tmds_lane_aligner.sv
// One TMDS lane: serial-to-parallel assembly with bit-slip boundary search
// driven by runs of control tokens, then a sticky lock.
module tmds_lane_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   serial_bit,
  input  logic                   realign,
  output logic [TMDS_WORD_W-1:0] word,
  output logic                   valid,
  output logic                   locked,
  output logic [3:0]             slip_count
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_TOKENS);

  logic [TMDS_WORD_W-1:0] sr_q, sr_d;
  logic [TMDS_WORD_W-1:0] word_q, word_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             slip_cnt_q, slip_cnt_d;
  logic [7:0]             hit_cnt_q, hit_cnt_d;
  logic                   slip_hold_q, slip_hold_d;
  logic                   valid_q, valid_d;
  aligner_state_t         state_q, state_d;

  logic       completing;
  logic       token;
  logic       do_slip;
  logic [7:0] hit_inc;

  always_comb begin
    sr_d        = {serial_bit, sr_q[TMDS_WORD_W-1:1]};
    completing  = (bit_cnt_q == 4'd9) && !slip_hold_q;
    token       = is_ctrl_token(sr_d);
    hit_inc     = hit_cnt_q + 8'd1;

    // A pending slip freezes the counter for one cycle, pushing the boundary later.
    if (slip_hold_q) begin
      bit_cnt_d = bit_cnt_q;
    end else if (bit_cnt_q == 4'd9) begin
      bit_cnt_d = 4'd0;
    end else begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    word_d      = word_q;
    valid_d     = completing;
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    do_slip     = 1'b0;

    if (completing) begin
      word_d = sr_d;
    end

    if (realign) begin
      state_d   = SEARCH;
      hit_cnt_d = 8'd0;
    end else if (completing) begin
      unique case (state_q)
        SEARCH: begin
          if (token) begin
            hit_cnt_d = 8'd1;
            state_d   = (LOCK_N == 8'd1) ? LOCKED : VERIFY;
          end else begin
            do_slip = 1'b1;
          end
        end
        VERIFY: begin
          if (token) begin
            hit_cnt_d = hit_inc;
            if (hit_inc == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            do_slip   = 1'b1;
            state_d   = SEARCH;
            hit_cnt_d = 8'd0;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d   = SEARCH;
          hit_cnt_d = 8'd0;
        end
      endcase
    end

    slip_hold_d = do_slip;
    if (do_slip) begin
      slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
    end else begin
      slip_cnt_d = slip_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sr_q        <= '0;
      word_q      <= '0;
      bit_cnt_q   <= 4'd0;
      slip_cnt_q  <= 4'd0;
      hit_cnt_q   <= 8'd0;
      slip_hold_q <= 1'b0;
      valid_q     <= 1'b0;
      state_q     <= SEARCH;
    end else begin
      sr_q        <= sr_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      slip_hold_q <= slip_hold_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
    end
  end

  assign word       = word_q;
  assign valid      = valid_q;
  assign locked     = (state_q == LOCKED);
  assign slip_count = slip_cnt_q;

endmodule

// File: rtl/tmds_deserializer.sv
// Three-lane TMDS receive front end; each lane aligns independently and
// a shared realign pulse sends every lane back to boundary search.
module tmds_deserializer
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 8
) (
  input  logic        pi_clk,
  input  logic        pi_rst,
  input  logic [2:0]  pi_serial,
  input  logic        pi_realign,
  output logic [9:0]  po_red,
  output logic [9:0]  po_green,
  output logic [9:0]  po_blue,
  output logic [2:0]  po_valid,
  output logic [2:0]  po_locked,
  output logic [11:0] po_slip_count
);

  logic [TMDS_WORD_W-1:0] lane_word [3];

  // Lane index matches pi_serial bit: 0 blue, 1 green, 2 red.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      tmds_lane_aligner #(
        .LOCK_TOKENS(LOCK_TOKENS)
      ) u_aligner (
        .clk        (pi_clk),
        .srst       (pi_rst),
        .serial_bit (pi_serial[gi]),
        .realign    (pi_realign),
        .word       (lane_word[gi]),
        .valid      (po_valid[gi]),
        .locked     (po_locked[gi]),
        .slip_count (po_slip_count[4*gi +: 4])
      );
    end
  endgenerate

  assign po_blue  = lane_word[0];
  assign po_green = lane_word[1];
  assign po_red   = lane_word[2];

endmodule
